// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter that sequences register-to-register transfers on the shared datapath bus.
// An accepted request spends one cycle driving the source, then one cycle loading the destination.
module bus_transfer_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CODE_W  = 5,
    parameter int NUM_SRC = 24
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*CODE_W-1:0]   req_src,
    input  logic [NUM_REQ*CODE_W-1:0]   req_dst,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_SRC-1:0]          src_out_en,
    output logic [NUM_SRC-1:0]          dst_in_en,
    output logic [2:0]                  grant_id,
    output logic                        busy,
    output logic                        code_err
);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

    localparam logic [CODE_W:0] CODE_LIMIT = (CODE_W+1)'(NUM_SRC);

    state_t            state;
    logic [2:0]        ptr;
    logic [CODE_W-1:0] dst_q;

    logic              found;
    logic [2:0]        gnt;
    logic [CODE_W-1:0] sel_src;
    logic [CODE_W-1:0] sel_dst;
    logic              bad_code;
    logic              accept;

    // Two passes give the wrap-around search: first from ptr upward, then from 0.
    always_comb begin
        found   = 1'b0;
        gnt     = '0;
        sel_src = '0;
        sel_dst = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found && req_valid[j] && j >= 32'(ptr)) begin
                found   = 1'b1;
                gnt     = 3'(j);
                sel_src = req_src[j*CODE_W +: CODE_W];
                sel_dst = req_dst[j*CODE_W +: CODE_W];
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found && req_valid[j]) begin
                found   = 1'b1;
                gnt     = 3'(j);
                sel_src = req_src[j*CODE_W +: CODE_W];
                sel_dst = req_dst[j*CODE_W +: CODE_W];
            end
        end
        bad_code = ({1'b0, sel_src} >= CODE_LIMIT) || ({1'b0, sel_dst} >= CODE_LIMIT);
        accept   = reset_n && (state == IDLE) && found;
        code_err = accept && bad_code;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            req_ready[j] = accept && (gnt == 3'(j));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            dst_q      <= '0;
            grant_id   <= '0;
            src_out_en <= '0;
            dst_in_en  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id <= gnt;
                        ptr      <= (gnt == 3'(NUM_REQ-1)) ? '0 : gnt + 3'd1;
                        dst_q    <= sel_dst;
                        if (!bad_code) begin
                            state      <= DRIVE;
                            busy       <= 1'b1;
                            src_out_en <= NUM_SRC'(1) << sel_src;
                        end
                    end
                end
                DRIVE: begin
                    dst_in_en <= NUM_SRC'(1) << dst_q;
                    state     <= LOAD;
                end
                LOAD: begin
                    src_out_en <= '0;
                    dst_in_en  <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Directed and randomized bench for bus_transfer_arbiter, checked each cycle against a
// transfer-countdown reference model.
module tb_bus_transfer_arbiter;

    localparam int NREQ = 2;
    localparam int CW   = 5;
    localparam int NSRC = 24;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*CW-1:0]    req_src;
    logic [NREQ*CW-1:0]    req_dst;
    logic [NREQ-1:0]       req_ready;
    logic [NSRC-1:0]       src_out_en;
    logic [NSRC-1:0]       dst_in_en;
    logic [2:0]            grant_id;
    logic                  busy;
    logic                  code_err;

    bus_transfer_arbiter #(.NUM_REQ(NREQ), .CODE_W(CW), .NUM_SRC(NSRC)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_src(req_src),
        .req_dst(req_dst), .req_ready(req_ready), .src_out_en(src_out_en),
        .dst_in_en(dst_in_en), .grant_id(grant_id), .busy(busy), .code_err(code_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining cycles of the current transfer plus arbitration pointer.
    int m_cnt = 0;
    int m_ptr = 0;
    int m_gid = 0;
    int m_src = 0;
    int m_dst = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [CW-1:0] s, input logic [CW-1:0] d);
        req_src[i*CW +: CW] = s;
        req_dst[i*CW +: CW] = d;
    endtask

    function automatic logic [CW-1:0] rnd_code();
        if ($urandom_range(0, 7) == 0) return CW'($urandom_range(NSRC, 31));
        return CW'($urandom_range(0, NSRC-1));
    endfunction

    // One clock cycle: check outputs mid-cycle, then advance the model at the rising edge.
    task automatic step();
        bit   acc;
        int   g;
        int   s;
        int   d;
        bit   err;
        logic [31:0] exp_ready;
        acc = 0; g = 0; s = 0; d = 0; err = 0;
        @(negedge clk);
        if (reset_n && m_cnt == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (!acc && req_valid[idx]) begin
                    acc = 1;
                    g   = idx;
                end
            end
        end
        if (acc) begin
            s   = int'(req_src[g*CW +: CW]);
            d   = int'(req_dst[g*CW +: CW]);
            err = (s >= NSRC) || (d >= NSRC);
        end
        exp_ready = acc ? (32'd1 << g) : 32'd0;
        chk("req_ready", 32'(req_ready), exp_ready);
        chk("code_err", 32'(code_err), 32'(acc && err));
        chk("src_out_en", 32'(src_out_en), (m_cnt > 0) ? (32'd1 << m_src) : 32'd0);
        chk("dst_in_en", 32'(dst_in_en), (m_cnt == 1) ? (32'd1 << m_dst) : 32'd0);
        chk("busy", 32'(busy), 32'(m_cnt > 0));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("src_onehot", 32'($countones(src_out_en) <= 1), 32'd1);
        chk("dst_onehot", 32'($countones(dst_in_en) <= 1), 32'd1);
        @(posedge clk);
        if (!reset_n) begin
            m_cnt = 0; m_ptr = 0; m_gid = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (acc) begin
            m_ptr = (g + 1) % NREQ;
            m_gid = g;
            if (!err) begin
                m_cnt = 2; m_src = s; m_dst = d;
            end
        end
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_src   = '0;
        req_dst   = '0;
        repeat (2) step();
        reset_n = 1'b1;

        // Contention from reset: both requesters held valid.
        set_req(0, 5'd1, 5'd2);
        set_req(1, 5'd4, 5'd7);
        req_valid = 2'b11;
        repeat (13) step();
        req_valid = '0;
        repeat (3) step();

        // Single transfer R3 -> PC.
        set_req(0, 5'd3, 5'd20);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        repeat (3) step();

        // Invalid source code on requester 1.
        set_req(1, 5'd27, 5'd5);
        req_valid = 2'b10;
        step();
        req_valid = '0;
        repeat (2) step();

        // Edge codes, then src == dst.
        set_req(0, 5'd23, 5'd0);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        repeat (2) step();
        set_req(0, 5'd16, 5'd16);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        repeat (3) step();

        // Withdrawal: requester 1 appears only while busy; pointer must still favour it.
        set_req(0, 5'd5, 5'd6);
        set_req(1, 5'd8, 5'd9);
        req_valid = 2'b01;
        step();
        req_valid = 2'b10;
        step();
        req_valid = '0;
        repeat (2) step();
        req_valid = 2'b11;
        step();
        chk("withdraw_grant", 32'(grant_id), 32'd1);
        req_valid = '0;
        repeat (3) step();

        // Reset during LOAD: enables must drop without a clock edge.
        set_req(1, 5'd10, 5'd11);
        req_valid = 2'b10;
        step();
        req_valid = '0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_src_async", 32'(src_out_en), 32'd0);
        chk("rst_dst_async", 32'(dst_in_en), 32'd0);
        chk("rst_busy_async", 32'(busy), 32'd0);
        m_cnt = 0; m_ptr = 0; m_gid = 0;
        @(posedge clk);
        #1;
        step();
        reset_n = 1'b1;
        set_req(0, 5'd12, 5'd13);
        req_valid = 2'b11;
        step();
        chk("post_reset_grant", 32'(grant_id), 32'd0);
        req_valid = '0;
        repeat (3) step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) set_req(i, rnd_code(), rnd_code());
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
